// File: rtl/common_pkg.sv
// Shared MDU definitions: operation encoding, iteration count and operand classification helpers.
// Used by mdu_iter_step and mdu_sequencer.
package common;

   localparam int MDU_ITERATIONS = 32;

   typedef enum logic [2:0] {
      MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
   } mdu_op_type;

   function automatic logic op_is_div(input mdu_op_type op);
      return op inside {DIV, DIVU, REM, REMU};
   endfunction

   function automatic logic op_is_rem(input mdu_op_type op);
      return op inside {REM, REMU};
   endfunction

   function automatic logic op_a_signed(input mdu_op_type op);
      return op inside {MUL, MULH, MULHSU, DIV, REM};
   endfunction

   function automatic logic op_b_signed(input mdu_op_type op);
      return op inside {MUL, MULH, DIV, REM};
   endfunction

   // Divide-by-zero and the single signed-overflow case have architecturally fixed results.
   function automatic logic op_is_special(input mdu_op_type op, input logic [31:0] a,
                                          input logic [31:0] b);
      return op_is_div(op) &&
             ((b == 32'h0) ||
              ((op inside {DIV, REM}) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
   endfunction

   function automatic logic [31:0] special_result(input mdu_op_type op, input logic [31:0] a,
                                                  input logic [31:0] b);
      if (b == 32'h0) return op_is_rem(op) ? a : 32'hFFFF_FFFF;
      return op_is_rem(op) ? 32'h0 : 32'h8000_0000;
   endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration on magnitudes: shift-add multiply or restoring divide.
// {hi, lo} holds {product high, product low/multiplier} or {remainder, dividend/quotient}.
module mdu_iter_step (
   input  logic        is_div_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   input  logic [31:0] b_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   logic [32:0] sum;
   logic [32:0] shifted;
   logic        fits;

   always_comb begin
      sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : 33'd0);
      shifted = {hi_i, lo_i[31]};
      fits    = shifted >= {1'b0, b_i};
      if (is_div_i) begin
         // The partial remainder stays below the divisor, so the difference fits in 32 bits.
         hi_o = fits ? (shifted[31:0] - b_i) : shifted[31:0];
         lo_o = {lo_i[30:0], fits};
      end else begin
         hi_o = sum[32:1];
         lo_o = {sum[0], lo_i[31:1]};
      end
   end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative 32-bit multiply/divide sequencer (IDLE -> CALC x32 -> FINISH -> DONE).
// Define MDU_EARLY_OUT_EN to retire divide-by-zero and signed overflow straight from IDLE.
module mdu_sequencer
   import common::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  mdu_op_type  op,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   input  logic        flush,
   output logic        stall,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH, S_DONE} state_e;

   localparam int               CNT_W    = $clog2(MDU_ITERATIONS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_ITERATIONS - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mdu_op_type       op_q, op_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d, b_q, b_d;
   logic             neg_q, neg_d;
   logic             special_q, special_d;
   logic [31:0]      special_res_q, special_res_d;
   logic [31:0]      result_q, result_d;

   logic        op_q_div;
   logic [31:0] step_hi, step_lo;
   logic        neg_a, neg_b;
   logic [31:0] mag_a, mag_b;
   logic [63:0] prod_fix;
   logic [31:0] div_sel, final_res;

   assign op_q_div = op_is_div(op_q);

   mdu_iter_step u_step (
      .is_div_i (op_q_div),
      .hi_i     (hi_q),
      .lo_i     (lo_q),
      .b_i      (b_q),
      .hi_o     (step_hi),
      .lo_o     (step_lo)
   );

   always_comb begin
      neg_a = op_a_signed(op) && data1[31];
      neg_b = op_b_signed(op) && data2[31];
      mag_a = neg_a ? (~data1 + 32'd1) : data1;
      mag_b = neg_b ? (~data2 + 32'd1) : data2;
   end

   // Sign correction: product and quotient carry sign(a)^sign(b), remainder carries sign(a).
   always_comb begin
      prod_fix = neg_q ? (~{hi_q, lo_q} + 64'd1) : {hi_q, lo_q};
      div_sel  = op_is_rem(op_q) ? hi_q : lo_q;
      if (special_q)           final_res = special_res_q;
      else if (op_q_div)       final_res = neg_q ? (~div_sel + 32'd1) : div_sel;
      else if (op_q == MUL)    final_res = prod_fix[31:0];
      else                     final_res = prod_fix[63:32];
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path through this block can infer a latch.
      state_d       = state_q;
      cnt_d         = cnt_q;
      op_d          = op_q;
      hi_d          = hi_q;
      lo_d          = lo_q;
      b_d           = b_q;
      neg_d         = neg_q;
      special_d     = special_q;
      special_res_d = special_res_q;
      result_d      = result_q;
      stall         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               stall         = 1'b1;
               op_d          = op;
               hi_d          = 32'h0;
               lo_d          = mag_a;
               b_d           = mag_b;
               cnt_d         = '0;
               neg_d         = op_is_rem(op) ? neg_a : (neg_a ^ neg_b);
               special_d     = op_is_special(op, data1, data2);
               special_res_d = special_result(op, data1, data2);
`ifdef MDU_EARLY_OUT_EN
               state_d = special_d ? S_DONE : S_CALC;
               if (special_d) result_d = special_res_d;
`else
               state_d = S_CALC;
`endif
            end
         end
         S_CALC: begin
            stall = 1'b1;
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_d = S_FINISH;
         end
         S_FINISH: begin
            stall    = 1'b1;
            result_d = final_res;
            state_d  = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
      if (!reset_n) stall = 1'b0;
   end

   // NOTE: non-blocking assignments here so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         op_q          <= MUL;
         hi_q          <= 32'h0;
         lo_q          <= 32'h0;
         b_q           <= 32'h0;
         neg_q         <= 1'b0;
         special_q     <= 1'b0;
         special_res_q <= 32'h0;
         result_q      <= 32'h0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         op_q          <= op_d;
         hi_q          <= hi_d;
         lo_q          <= lo_d;
         b_q           <= b_d;
         neg_q         <= neg_d;
         special_q     <= special_d;
         special_res_q <= special_res_d;
         result_q      <= result_d;
      end
   end

   assign done   = (state_q == S_DONE);
   assign result = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed vectors plus a per-cycle latency/result model.
// Build with MDU_EARLY_OUT_EN defined to check the early-out latency.
module tb_mdu_sequencer;
   import common::*;

   localparam int LAT_NORMAL  = 34;
`ifdef MDU_EARLY_OUT_EN
   localparam int LAT_SPECIAL = 1;
`else
   localparam int LAT_SPECIAL = 34;
`endif

   logic        clk     = 1'b0;
   logic        reset_n = 1'b0;
   logic        start   = 1'b0;
   logic        flush   = 1'b0;
   mdu_op_type  op      = MUL;
   logic [31:0] data1   = 32'h0;
   logic [31:0] data2   = 32'h0;
   logic        stall, done;
   logic [31:0] result;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic        m_busy    = 1'b0;
   int          m_done_at = 0;
   logic [31:0] m_pend    = 32'h0;
   logic [31:0] m_res     = 32'h0;
   logic        m_acc, e_done, e_stall;

   mdu_sequencer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .data1   (data1),
      .data2   (data2),
      .flush   (flush),
      .stall   (stall),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, got, want);
      end
   endtask

   // Reference arithmetic straight from the ISA rules, using 64-bit products and native / and %.
   function automatic logic [31:0] model_eval(input mdu_op_type o, input logic [31:0] a,
                                              input logic [31:0] b);
      logic signed [63:0] sa, sb;
      logic [63:0] ua, ub, p;
      logic [31:0] r;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'h0, a};
      ub = {32'h0, b};
      r  = 32'h0;
      case (o)
         MUL:    begin p = ua * ub;           r = p[31:0];  end
         MULH:   begin p = sa * sb;           r = p[63:32]; end
         MULHSU: begin p = sa * $signed(ub);  r = p[63:32]; end
         MULHU:  begin p = ua * ub;           r = p[63:32]; end
         DIV:    if (b == 0) r = 32'hFFFF_FFFF;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                 else r = $signed(a) / $signed(b);
         DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         REM:    if (b == 0) r = a;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                 else r = $signed(a) % $signed(b);
         REMU:   r = (b == 0) ? a : a % b;
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   function automatic int model_lat(input mdu_op_type o, input logic [31:0] a, input logic [31:0] b);
      if ((o inside {DIV, DIVU, REM, REMU}) &&
          (b == 0 || ((o inside {DIV, REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return LAT_SPECIAL;
      return LAT_NORMAL;
   endfunction

   // Per-cycle compare: an accepted op finishes model_lat cycles after acceptance.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            m_busy  = 1'b0;
            m_res   = 32'h0;
            m_acc   = 1'b0;
            e_done  = 1'b0;
            e_stall = 1'b0;
         end else begin
            m_acc = !m_busy && start && !flush;
            if (m_busy && cyc == m_done_at) m_res = m_pend;
            e_done  = m_busy && (cyc == m_done_at);
            e_stall = m_acc || (m_busy && cyc < m_done_at);
         end
         check($sformatf("cyc%0d done", cyc), {31'h0, done}, {31'h0, e_done});
         check($sformatf("cyc%0d stall", cyc), {31'h0, stall}, {31'h0, e_stall});
         check($sformatf("cyc%0d result", cyc), result, m_res);
         if (reset_n) begin
            if (m_busy && (cyc == m_done_at || flush)) m_busy = 1'b0;
            if (m_acc) begin
               m_busy    = 1'b1;
               m_done_at = cyc + model_lat(op, data1, data2);
               m_pend    = model_eval(op, data1, data2);
            end
         end
      end
   end

   task automatic run_op(input mdu_op_type o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input int want_lat, input string name);
      int   s, n_stall;
      logic got;
      op = o; data1 = a; data2 = b; start = 1'b1;
      s = cyc; n_stall = 0; got = 1'b0;
      @(negedge clk);
      if (stall) n_stall++;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (done) got = 1'b1;
         else if (stall) n_stall++;
      end
      check({name, " done seen"}, {31'h0, got}, 32'd1);
      check({name, " latency"}, 32'(cyc - s), 32'(want_lat));
      check({name, " stall cycles"}, 32'(n_stall), 32'(want_lat));
      check({name, " result"}, result, want);
      @(posedge clk); #1;
   endtask

   initial begin
      int s, n_done;
      start = 1'b1;
      #1;
      check("reset stall", {31'h0, stall}, 32'd0);
      check("reset done", {31'h0, done}, 32'd0);
      check("reset result", result, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0; reset_n = 1'b1;
      @(posedge clk); #1;

      run_op(MUL,    32'd7,          32'd6,          32'h0000_002A, LAT_NORMAL,  "mul 7x6");
      run_op(MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, LAT_NORMAL,  "mulh -1x-1");
      run_op(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, LAT_NORMAL,  "mulhu max");
      run_op(MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, LAT_NORMAL,  "mulhsu -1xmax");
      run_op(MUL,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, LAT_NORMAL,  "mul min x -1");
      run_op(DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, LAT_NORMAL,  "div -7/2");
      run_op(REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, LAT_NORMAL,  "rem -7/2");
      run_op(REM,    32'd7,          32'hFFFF_FFFE,  32'h0000_0001, LAT_NORMAL,  "rem 7/-2");
      run_op(DIVU,   32'd100,        32'd7,          32'h0000_000E, LAT_NORMAL,  "divu 100/7");
      run_op(REMU,   32'd100,        32'd7,          32'h0000_0002, LAT_NORMAL,  "remu 100/7");
      run_op(DIV,    32'd5,          32'd0,          32'hFFFF_FFFF, LAT_SPECIAL, "div 5/0");
      run_op(REMU,   32'd5,          32'd0,          32'h0000_0005, LAT_SPECIAL, "remu 5/0");
      run_op(REM,    32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB, LAT_SPECIAL, "rem -5/0");
      run_op(DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, LAT_SPECIAL, "div ovf");
      run_op(REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, LAT_SPECIAL, "rem ovf");
      run_op(REMU,   32'd100,        32'd7,          32'h0000_0002, LAT_NORMAL,  "remu reload");

      // Flush a DIV in cycle T+10, then restart in T+11.
      op = DIV; data1 = 32'd1000; data2 = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush result held", result, 32'h0000_0002);
      check("flush stall low", {31'h0, stall}, 32'd0);
      run_op(REMU, 32'd1000, 32'd7, 32'h0000_0006, LAT_NORMAL, "after flush");

      // Reset pulse at T+5 of an in-flight op.
      op = MULHU; data1 = 32'h1234; data2 = 32'h10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst pulse stall", {31'h0, stall}, 32'd0);
      check("rst pulse done", {31'h0, done}, 32'd0);
      check("rst pulse result", result, 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      n_done = 0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("no done after reset", 32'(n_done), 32'd0);

      // Start held high through CALC with changing operands must not re-sample.
      @(posedge clk); #1;
      op = MULHU; data1 = 32'h0001_0000; data2 = 32'h0001_0000; start = 1'b1;
      s = cyc;
      @(posedge clk); #1;
      op = MUL; data1 = 32'hDEAD; data2 = 32'hBEEF;
      repeat (28) @(posedge clk);
      #1;
      start = 1'b0;
      n_done = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done) begin
            n_done++;
            check("held start latency", 32'(cyc - s), 32'(LAT_NORMAL));
         end
      end
      check("held start single done", 32'(n_done), 32'd1);
      check("held start result", result, 32'h0000_0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
- REQ-001 Parameters: none; operand width fixed at 32 bits, iteration count taken from package constant MDU_ITERATIONS (= 32).
- REQ-002 clk  input  1  single clock; all state updates on rising edge.
- REQ-003 reset_n  input  1  asynchronous, active-low reset.
- REQ-004 start  input  1  request a new operation; sampled only in IDLE.
- REQ-005 op  input  mdu_op_type  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; sampled with start.
- REQ-006 data1  input  32  rs1 operand (multiplicand / dividend); sampled with start.
- REQ-007 data2  input  32  rs2 operand (multiplier / divisor); sampled with start.
- REQ-008 flush  input  1  synchronous abort from pipeline control.
- REQ-009 stall  output  1  freeze upstream pipeline while an operation is in flight.
- REQ-010 done  output  1  one-cycle pulse; result valid.
- REQ-011 result  output  32  registered result; held until the next done.

Function
- REQ-012 States: IDLE, CALC, FINISH, DONE; encoding private to the module.
- REQ-013 IDLE: start=1 and flush=0 -> latch op, operands and operand signs; clear iteration counter; -> CALC.
- REQ-014 CALC: one radix-2 iteration per cycle (shift-add multiply, restoring divide on magnitudes); counter increments; -> FINISH after iteration MDU_ITERATIONS-1.
- REQ-015 FINISH: apply sign correction; select high/low product word or quotient/remainder; register result; -> DONE.
- REQ-016 DONE: done=1 for exactly one cycle; -> IDLE unconditionally; start in DONE is ignored.
- REQ-017 Latency: start sampled at edge T -> done=1 in cycle T+34; next start accepted at edge T+35 at earliest.
- REQ-018 stall = (IDLE and start and not flush) or CALC or FINISH; stall is 0 in DONE.
- REQ-019 MUL returns low 32 bits of the product; MULH/MULHSU/MULHU return high 32 bits, with signed x signed, signed x unsigned and unsigned x unsigned operands respectively.
- REQ-020 Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
- REQ-021 Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> data1.
- REQ-022 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV -> 0x80000000, REM -> 0x00000000.
- REQ-023 flush=1 in any state -> IDLE next edge; done stays 0; result retains its previous value; flush overrides a coincident start.
- REQ-024 start while in CALC or FINISH has no effect; operands and op are not re-sampled.

Reset
- REQ-025 reset_n=0 asynchronously forces IDLE, result=0, done=0, counter=0; stall=0 while reset is asserted.
- REQ-026 Reset mid-operation discards the operation; no done pulse follows release.

Configuration
- REQ-027 MDU_EARLY_OUT_EN defined: divide-by-zero and signed-overflow cases go IDLE -> DONE directly, so done=1 in cycle T+1, and stall is 1 only in the accepting cycle.
- REQ-028 MDU_EARLY_OUT_EN undefined: these cases take the full REQ-017 latency; result values are identical in both builds.

Structure
- REQ-029 Package common holds mdu_op_type (3-bit enum, order as in REQ-005) and MDU_ITERATIONS.
- REQ-030 One sub-module, mdu_iter_step, holds the combinational single-iteration add/subtract-and-shift datapath; mdu_sequencer holds the FSM, counter and registers.

Verification
- REQ-031 MUL 7 x 6 -> done at T+34, result 0x0000002A; stall=1 in cycles T..T+33.
- REQ-032 MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE.
- REQ-033 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14.
- REQ-034 DIV 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000; done at T+1 with MDU_EARLY_OUT_EN, T+34 without.
- REQ-035 flush at T+10 of a DIV -> IDLE at T+11, no done, result unchanged; a new start at T+11 completes normally.
- REQ-036 reset_n pulsed low at T+5 -> outputs zero immediately; start held during CALC -> ignored, single done observed.
